// File: rtl/i2c_cmd_sequencer_if.sv
// i2c_cmd_sequencer_if: host request/response signals plus the register bus
// toward i2c_master_top. The slave modport is the sequencer's view; the master
// modport is the view of whatever drives requests and returns bus read data.
interface i2c_cmd_sequencer_if;
    // Host request side
    logic       Req;
    logic       ReqRd;
    logic [6:0] ReqSadr;
    logic [7:0] ReqMemAddr;
    logic [7:0] ReqWdata;
    logic       Busy;
    logic       Done;
    logic       Err;
    logic [7:0] RdData;
    // Register bus side (i2c_master_top)
    logic [2:0] Addr;
    logic [7:0] Dout;
    logic [7:0] Din;
    logic       Wr;

    modport slave (
        input  Req, ReqRd, ReqSadr, ReqMemAddr, ReqWdata, Din,
        output Busy, Done, Err, RdData, Addr, Dout, Wr
    );

    modport master (
        output Req, ReqRd, ReqSadr, ReqMemAddr, ReqWdata, Din,
        input  Busy, Done, Err, RdData, Addr, Dout, Wr
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: turns a single host request (write one byte / read one
// byte at a slave memory address) into the TXR/CR/SR register traffic that an
// i2c_master_top core needs, polling SR between phases and aborting with a
// stop when the slave NACKs an address or memory-address byte.
// Optional build macro I2C_SEQ_INIT_EN: after reset, program PRER=PRESCALE and
// CTR=8'h80 before accepting requests. Without it the host owns core setup.
module i2c_cmd_sequencer #(
    parameter logic [2:0] ADDR_PRER    = 3'd0,
    parameter logic [2:0] ADDR_CTR     = 3'd2,
    parameter logic [2:0] ADDR_TXR_RXR = 3'd3,
    parameter logic [2:0] ADDR_CR_SR   = 3'd4,
    parameter logic [7:0] PRESCALE     = 8'h07
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    i2c_cmd_sequencer_if.slave    bus
);

    // Command register values (STA=7, STO=6, RD=5, WR=4, ACK=3)
    localparam logic [7:0] CR_START_WR    = 8'h90;
    localparam logic [7:0] CR_WR          = 8'h10;
    localparam logic [7:0] CR_WR_STOP     = 8'h50;
    localparam logic [7:0] CR_RD_NAK_STOP = 8'h68;
    localparam logic [7:0] CR_STOP        = 8'h40;
    localparam logic [7:0] CTR_CORE_EN    = 8'h80;

    // Status register bit positions
    localparam int SR_TIP   = 1;
    localparam int SR_BUSY  = 6;
    localparam int SR_RXACK = 7;

    typedef enum logic [3:0] {
`ifdef I2C_SEQ_INIT_EN
        RESET_INIT,
`endif
        IDLE,
        WR_TXR,
        WR_CR,
        POLL_ADDR,
        POLL_CHK,
        GET_RXR,
        STOP_CR,
        DONE
    } state_t;

`ifdef I2C_SEQ_INIT_EN
    localparam state_t RESET_STATE = RESET_INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;     // 0: slave addr, 1: mem addr, 2: data / re-addr, 3: read byte
    logic       rd_q, rd_d;
    logic [6:0] sadr_q, sadr_d;
    logic [7:0] mem_q, mem_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wait_busy_q, wait_busy_d; // last CR issued a stop: poll also waits for bus free
    logic       abort_q, abort_d;         // stop after NACK is in flight
    logic       rx_pend_q, rx_pend_d;     // RXR read presented, Din valid next cycle
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
`ifdef I2C_SEQ_INIT_EN
    logic [1:0] init_step_q, init_step_d;
`endif

    logic [7:0] txr_byte;
    logic [7:0] cr_byte;
    logic [2:0] bus_addr;
    logic [7:0] bus_dout;
    logic       bus_wr;

    // TXR and CR contents for the current phase
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        txr_byte = 8'h00;
        cr_byte  = CR_START_WR;
        case (phase_q)
            2'd0: begin
                txr_byte = {sadr_q, 1'b0};
                cr_byte  = CR_START_WR;
            end
            2'd1: begin
                txr_byte = mem_q;
                cr_byte  = CR_WR;
            end
            2'd2: begin
                txr_byte = rd_q ? {sadr_q, 1'b1} : wdata_q;
                cr_byte  = rd_q ? CR_START_WR : CR_WR_STOP;
            end
            default: begin
                txr_byte = 8'h00;
                cr_byte  = CR_RD_NAK_STOP;
            end
        endcase
    end

    // Next-state, bus access and register updates
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rd_d        = rd_q;
        sadr_d      = sadr_q;
        mem_d       = mem_q;
        wdata_d     = wdata_q;
        wait_busy_d = wait_busy_q;
        abort_d     = abort_q;
        rx_pend_d   = rx_pend_q;
        busy_d      = busy_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
`ifdef I2C_SEQ_INIT_EN
        init_step_d = init_step_q;
`endif
        bus_addr    = 3'd0;
        bus_dout    = 8'h00;
        bus_wr      = 1'b0;

        case (state_q)
`ifdef I2C_SEQ_INIT_EN
            RESET_INIT: begin
                busy_d = 1'b1;
                case (init_step_q)
                    2'd0: init_step_d = 2'd1;
                    2'd1: begin
                        bus_wr      = 1'b1;
                        bus_addr    = ADDR_PRER;
                        bus_dout    = PRESCALE;
                        init_step_d = 2'd2;
                    end
                    default: begin
                        bus_wr   = 1'b1;
                        bus_addr = ADDR_CTR;
                        bus_dout = CTR_CORE_EN;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                endcase
            end
`endif
            IDLE: begin
                if (bus.Req) begin
                    rd_d    = bus.ReqRd;
                    sadr_d  = bus.ReqSadr;
                    mem_d   = bus.ReqMemAddr;
                    wdata_d = bus.ReqWdata;
                    phase_d = 2'd0;
                    abort_d = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = WR_TXR;
                end
            end
            WR_TXR: begin
                bus_wr   = 1'b1;
                bus_addr = ADDR_TXR_RXR;
                bus_dout = txr_byte;
                state_d  = WR_CR;
            end
            WR_CR: begin
                bus_wr      = 1'b1;
                bus_addr    = ADDR_CR_SR;
                bus_dout    = cr_byte;
                wait_busy_d = cr_byte[6];
                state_d     = POLL_ADDR;
            end
            STOP_CR: begin
                bus_wr      = 1'b1;
                bus_addr    = ADDR_CR_SR;
                bus_dout    = CR_STOP;
                wait_busy_d = 1'b1;
                abort_d     = 1'b1;
                state_d     = POLL_ADDR;
            end
            POLL_ADDR: begin
                bus_addr = ADDR_CR_SR;
                state_d  = POLL_CHK;
            end
            POLL_CHK: begin
                // SR read issued last cycle is on Din now; no timeout, stretching just loops here
                if (bus.Din[SR_TIP] || (wait_busy_q && bus.Din[SR_BUSY])) begin
                    state_d = POLL_ADDR;
                end else if (abort_q) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (phase_q == 2'd3) begin
                    state_d = GET_RXR;
                end else if (!rd_q && phase_q == 2'd2) begin
                    // Stop already went out with the data byte, so a NACK only flags
                    err_d   = bus.Din[SR_RXACK];
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (bus.Din[SR_RXACK]) begin
                    state_d = STOP_CR;
                end else begin
                    phase_d = phase_q + 2'd1;
                    // The read-byte phase is a CR command only; nothing to load into TXR
                    state_d = (rd_q && phase_q == 2'd2) ? WR_CR : WR_TXR;
                end
            end
            GET_RXR: begin
                if (!rx_pend_q) begin
                    bus_addr  = ADDR_TXR_RXR;
                    rx_pend_d = 1'b1;
                end else begin
                    rx_pend_d = 1'b0;
                    rdata_d   = bus.Din;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= RESET_STATE;
            phase_q     <= 2'd0;
            rd_q        <= 1'b0;
            sadr_q      <= 7'h00;
            mem_q       <= 8'h00;
            wdata_q     <= 8'h00;
            wait_busy_q <= 1'b0;
            abort_q     <= 1'b0;
            rx_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
`ifdef I2C_SEQ_INIT_EN
            init_step_q <= 2'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            phase_q     <= phase_d;
            rd_q        <= rd_d;
            sadr_q      <= sadr_d;
            mem_q       <= mem_d;
            wdata_q     <= wdata_d;
            wait_busy_q <= wait_busy_d;
            abort_q     <= abort_d;
            rx_pend_q   <= rx_pend_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
`ifdef I2C_SEQ_INIT_EN
            init_step_q <= init_step_d;
`endif
        end
    end

    assign bus.Addr   = bus_addr;
    assign bus.Dout   = bus_dout;
    assign bus.Wr     = bus_wr;
    assign bus.Busy   = busy_q;
    assign bus.Done   = (state_q == DONE);
    assign bus.Err    = err_q;
    assign bus.RdData = rdata_q;

endmodule
